store_narrow: RTL
=================

Name: store_narrow

Overview:
Store-side data path unit. It narrows a 32-bit register operand to a byte, halfword or word write. It places the value on the correct byte lanes with byte enables and issues it to data memory over a req/ack handshake. This is the inverse of the load-path sign extension: it can optionally flag a narrowing that loses information, i.e. when the upper bits are not copies of the narrowed value's sign bit. It sits between the EX/MEM stage register and the data memory port.

Parameters:
ADDR_W, 32, byte-address width.
TIMEOUT, 16, max cycles to wait for mem_ack before abort (1..255).

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  store request valid
in_ready  out  1  unit can accept a request
in_addr  in  ADDR_W  byte address
in_data  in  32  register operand (rt)
in_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
in_chk  in  1  enable lossless-narrowing check
mem_req  out  1  memory write request
mem_ack  in  1  memory accepted write (single-cycle pulse)
mem_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0
mem_wdata  out  32  lane-placed data
mem_be  out  4  byte enables, bit i = bits [8i+7:8i]
done  out  1  one-cycle pulse, store completed
err_valid  out  1  one-cycle pulse, error/warning reported
err_code  out  2  01 misaligned, 10 truncation loss, 11 timeout

Behaviour:
- Reset (async, reset_n=0): state IDLE; in_ready=1; mem_req=0; mem_addr=0; mem_wdata=0; mem_be=0; done=0; err_valid=0; err_code=0; timeout counter=0.
- Reset asserted mid-transaction: the request is dropped with no done/err pulse. After release the unit is in IDLE.
- FSM states are IDLE and REQ. in_ready = (state==IDLE).
- IDLE, in_valid=1 (accept cycle N):
  - Misaligned means halfword with addr[0]=1, word with addr[1:0]!=0, or size=11. The unit pulses err_valid at N+1 with err_code=01, issues no memory request and stays in IDLE.
  - Otherwise it registers addr, data and enables, moves to REQ, and mem_req=1 from N+1.
- Lane placement, with a = addr[1:0]:
  - Byte: mem_wdata = {4{d[7:0]}}, mem_be = 1<<a.
  - Halfword: mem_wdata = {2{d[15:0]}}, mem_be = 0011 if a=0, 1100 if a=2.
  - Word: mem_wdata = d, mem_be = 1111.
- Truncation check applies only when in_chk=1:
  - Byte: d[31:8] must equal {24{d[7]}}.
  - Halfword: d[31:16] must equal {16{d[15]}}.
  - Word: never fails.
  - On failure the store is still issued. err_valid with err_code=10 pulses at N+1, concurrently with the first mem_req cycle.
- REQ:
  - mem_req, mem_addr, mem_wdata and mem_be are held stable until mem_ack.
  - The counter increments each cycle without ack.
  - mem_ack=1 at cycle M: done=1 at M+1, mem_req=0 at M+1, state IDLE (in_ready=1 at M+1).
  - If the counter reaches TIMEOUT without ack: mem_req drops, err_valid with err_code=11, no done, return to IDLE.
  - If ack and timeout occur in the same cycle, ack wins.
- mem_ack while in IDLE is ignored.
- Throughput is at most one store per 2 cycles. There are no back-to-back accepts.
- done and err_valid are never both 1, except that a truncation warning may coincide with done for a zero-wait ack. In that case the earlier err pulse is at N+1 and done at N+2, so they never coincide in practice.

Decomposition:
- Shared package mem_pkg holds the size encodings (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10), the error codes (ERR_MISALIGN, ERR_TRUNC, ERR_TIMEOUT), and the FSM state enum.
- One combinational sub-module, store_lane_place, takes (size, a, d) and produces (wdata, be, misaligned, trunc_loss). It is reusable by a future store buffer.
- The FSM and the timeout counter remain in store_narrow.

Test Plan:
- Byte store, addr=0x1003, data=0xFFFFFF80, chk=1, ack after 2 cycles -> mem_addr=0x1000, wdata=0x80808080, be=1000, no err, done pulse 1 cycle after ack.
- Halfword, addr=0x2002, data=0x00012345, chk=1 -> err 10 at N+1; store still issued with wdata=0x23452345, be=1100, then done.
- Halfword, addr=0x2001 -> err 01 at N+1, mem_req never asserted, in_ready stays 1.
- Word, addr=0x3000, no ack, TIMEOUT=4 -> mem_req high exactly 4 cycles, then err 11; in_ready=1 next cycle.
- Word store in REQ, reset_n pulsed low mid-wait -> all outputs go to reset values immediately; no done/err after release.
- Back-to-back in_valid held high with zero-wait ack -> accepts every 2nd cycle, outputs stable while mem_req=1.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared encodings for the store data path.
//                Contents: access-size codes, error codes and the store FSM
//                state type.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

    // Access size encodings
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Error / warning codes reported on err_code
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TRUNC    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    // Store FSM states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/store_lane_place.sv
`default_nettype none
// ============================================================================
//  Module      : store_lane_place
//  Description : Combinational store lane placement.
//                Inputs: a size, the low address bits and the register operand.
//                Outputs: the lane-replicated write data, the byte enables,
//                a misalignment flag and a lossy-narrowing flag.
//                The lossy-narrowing flag is raw; qualifying it is the
//                caller's job.
//  Revision    : 1.0  initial release
// ============================================================================
module store_lane_place
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  a,
    input  logic [31:0] d,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        misaligned,
    output logic        trunc_loss
);

    // Replicate the narrowed value across lanes and select the enabled lanes
    always_comb begin
        wdata      = 32'h0;
        be         = 4'b0000;
        misaligned = 1'b0;
        trunc_loss = 1'b0;
        case (size)
            SZ_BYTE: begin
                wdata      = {4{d[7:0]}};
                be         = 4'b0001 << a;
                trunc_loss = (d[31:8] != {24{d[7]}});
            end
            SZ_HALF: begin
                wdata      = {2{d[15:0]}};
                be         = a[1] ? 4'b1100 : 4'b0011;
                misaligned = a[0];
                trunc_loss = (d[31:16] != {16{d[15]}});
            end
            SZ_WORD: begin
                wdata      = d;
                be         = 4'b1111;
                misaligned = (a != 2'b00);
            end
            default: begin
                // Reserved size is treated as an unservable access
                misaligned = 1'b1;
            end
        endcase
    end

endmodule : store_lane_place
`default_nettype wire

// File: rtl/store_narrow.sv
`default_nettype none
// ============================================================================
//  Module      : store_narrow
//  Description : Store-side narrowing unit. Takes one store request and
//                places it on byte lanes, then issues it to data memory over
//                a req/ack handshake with a timeout. Reports misaligned
//                accesses (no memory request is made) and optional lossy
//                narrowing (the store is still made).
//  Revision    : 1.0  initial release
// ============================================================================
module store_narrow
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_data,
    input  logic [1:0]        in_size,
    input  logic              in_chk,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              done,
    output logic              err_valid,
    output logic [1:0]        err_code
);

    // Last count value before the wait is declared expired
    localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;

    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic        w_misaligned;
    logic        w_trunc_loss;
    logic        w_accept;
    logic        w_reject;
    logic        w_acked;
    logic        w_expire;

    store_lane_place u_lane (
        .size       (in_size),
        .a          (in_addr[1:0]),
        .d          (in_data),
        .wdata      (w_wdata),
        .be         (w_be),
        .misaligned (w_misaligned),
        .trunc_loss (w_trunc_loss)
    );

    assign w_accept = (r_state == ST_IDLE) && in_valid && !w_misaligned;
    assign w_reject = (r_state == ST_IDLE) && in_valid &&  w_misaligned;
    assign w_acked  = (r_state == ST_REQ)  && mem_ack;
    // Ack takes priority over an expiring wait in the same cycle
    assign w_expire = (r_state == ST_REQ)  && !mem_ack && (r_cnt == c_cnt_last);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)             w_state_nxt = ST_REQ;
            ST_REQ:  if (w_acked || w_expire)  w_state_nxt = ST_IDLE;
            default:                           w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        in_ready = (r_state == ST_IDLE);
        mem_req  = (r_state == ST_REQ);
    end

    // Wait counter: cleared on accept, advances on every unacknowledged cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 8'd0;
        end else if (w_accept || w_acked || w_expire) begin
            r_cnt <= 8'd0;
        end else if (r_state == ST_REQ) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Capture the lane-placed request; held stable for the whole wait
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            mem_be    <= 4'b0000;
        end else if (w_accept) begin
            mem_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= w_wdata;
            mem_be    <= w_be;
        end
    end

    // Completion and error pulses; err_code is meaningful only with err_valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done      <= 1'b0;
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            done      <= w_acked;
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
            if (w_reject) begin
                err_valid <= 1'b1;
                err_code  <= ERR_MISALIGN;
            end else if (w_accept && in_chk && w_trunc_loss) begin
                err_valid <= 1'b1;
                err_code  <= ERR_TRUNC;
            end else if (w_expire) begin
                err_valid <= 1'b1;
                err_code  <= ERR_TIMEOUT;
            end
        end
    end

endmodule : store_narrow
`default_nettype wire
